// File: rtl/lsm_poly_eval_pkg.sv
// Fixed-point formats and FSM encoding shared by the LSM regression-line evaluator.
package lsm_poly_eval_pkg;

  localparam int XI_W    = 12;
  localparam int XI_FRAC = 4;
  localparam int B0_W    = 20;
  localparam int B0_FRAC = 8;
  localparam int B1_W    = 20;
  localparam int B1_FRAC = 12;
  localparam int YH_W    = 24;
  localparam int YH_FRAC = 8;

  // Product carries B1_FRAC+XI_FRAC fraction bits; the sum has one guard bit more.
  localparam int PROD_W    = B1_W + XI_W + 1;
  localparam int PROD_FRAC = B1_FRAC + XI_FRAC;
  localparam int SUM_W     = PROD_W + 1;
  localparam int B0_SH     = PROD_FRAC - B0_FRAC;
  localparam int Y_LSB     = PROD_FRAC - YH_FRAC;
  localparam int Y_MSB     = Y_LSB + YH_W - 1;
  localparam int PAY_SH    = YH_FRAC - XI_FRAC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [YH_W-1:0] sat_y(input logic [SUM_W-1:0] sum);
    logic [SUM_W-Y_MSB-1:0] guard;
    guard = sum[SUM_W-1:Y_MSB];
    if ((&guard) || (~|guard))
      return sum[Y_MSB:Y_LSB];
    else if (!sum[SUM_W-1])
      return {1'b0, {(YH_W-1){1'b1}}};
    else
      return {1'b1, {(YH_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/lsm_poly_eval_dp.sv
// Two-stage y_hat = beta0 + beta1*x datapath with saturation and exercise compare; 2-cycle latency.
// No backpressure: one sample per cycle in, results leave unconditionally.
module lsm_poly_eval_dp
  import lsm_poly_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [B0_W-1:0]   i_beta0,
  input  logic [B1_W-1:0]   i_beta1,
  input  logic              i_vld,
  input  logic [XI_W-1:0]   i_x,
  input  logic [XI_W-1:0]   i_pay,
  output logic              o_vld,
  output logic [YH_W-1:0]   o_y,
  output logic              o_ex
);

  logic [PROD_W-1:0] w_b1_ext;
  logic [PROD_W-1:0] w_x_ext;
  logic [PROD_W-1:0] w_prod;
  logic [SUM_W-1:0]  w_b0_ext;
  logic [SUM_W-1:0]  w_sum;
  logic [YH_W-1:0]   w_y;
  logic [YH_W-1:0]   w_pay_ext;
  logic              w_ex;

  logic              r_v1;
  logic [PROD_W-1:0] r_prod;
  logic [XI_W-1:0]   r_pay;
  logic              r_v2;
  logic [YH_W-1:0]   r_y;
  logic              r_ex;

  assign w_b1_ext = {{(PROD_W-B1_W){i_beta1[B1_W-1]}}, i_beta1};
  assign w_x_ext  = {{(PROD_W-XI_W){1'b0}}, i_x};
  assign w_prod   = $signed(w_b1_ext) * $signed(w_x_ext);

  assign w_b0_ext  = {{(SUM_W-B0_W-B0_SH){i_beta0[B0_W-1]}}, i_beta0, {B0_SH{1'b0}}};
  assign w_sum     = w_b0_ext + {r_prod[PROD_W-1], r_prod};
  assign w_y       = sat_y(w_sum);
  // Payoff is realigned to y_hat's 8 fraction bits; it is never negative.
  assign w_pay_ext = {{(YH_W-XI_W-PAY_SH){1'b0}}, r_pay, {PAY_SH{1'b0}}};
  assign w_ex      = (r_pay != '0) && ($signed(w_pay_ext) > $signed(w_y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_pay  <= '0;
      r_v2   <= 1'b0;
      r_y    <= '0;
      r_ex   <= 1'b0;
    end else begin
      r_v1   <= i_vld;
      r_prod <= w_prod;
      r_pay  <= i_pay;
      r_v2   <= r_v1;
      r_y    <= w_y;
      r_ex   <= r_v1 && w_ex;
    end
  end

  assign o_vld = r_v2;
  assign o_y   = r_y;
  assign o_ex  = r_ex;

endmodule

// File: rtl/lsm_poly_eval.sv
// Streams N samples through the fitted line, flags early exercise and counts it; done 3 cycles after last sample.
// No backpressure: samples are taken whenever in_valid is high in RUN; extra samples are dropped.
module lsm_poly_eval
  import lsm_poly_eval_pkg::*;
#(
  parameter int N = 256,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [B0_W-1:0]   beta0,
  input  logic [B1_W-1:0]   beta1,
  input  logic              in_valid,
  input  logic [XI_W-1:0]   x_in,
  input  logic [XI_W-1:0]   pay_in,
  output logic              busy,
  output logic              out_valid,
  output logic [YH_W-1:0]   y_hat,
  output logic              exercise,
  output logic              done,
  output logic [CNT_W-1:0]  ex_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drain;
  logic [CNT_W-1:0] r_ex_cnt;
  logic [B0_W-1:0]  r_beta0;
  logic [B1_W-1:0]  r_beta1;
  logic             w_dp_vld;
  logic [YH_W-1:0]  w_dp_y;
  logic             w_dp_ex;

  assign w_last = w_accept && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_ok = 1'b0;
    w_accept   = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE:  w_start_ok = start;
      S_RUN:   begin w_accept = in_valid; w_busy = 1'b1; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_drain  <= 1'b0;
      r_ex_cnt <= '0;
      r_beta0  <= '0;
      r_beta1  <= '0;
    end else begin
      // Second DRAIN cycle is the one where r_drain reads back high.
      r_drain <= (r_state == S_DRAIN);
      if (w_start_ok) begin
        r_beta0  <= beta0;
        r_beta1  <= beta1;
        r_cnt    <= '0;
        r_ex_cnt <= '0;
      end else begin
        if (w_accept)
          r_cnt <= r_cnt + CNT_W'(1);
        if (w_dp_vld && w_dp_ex && (r_ex_cnt != CNT_MAX))
          r_ex_cnt <= r_ex_cnt + CNT_W'(1);
      end
    end
  end

  lsm_poly_eval_dp u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_beta0 (r_beta0),
    .i_beta1 (r_beta1),
    .i_vld   (w_accept),
    .i_x     (x_in),
    .i_pay   (pay_in),
    .o_vld   (w_dp_vld),
    .o_y     (w_dp_y),
    .o_ex    (w_dp_ex)
  );

  assign busy      = w_busy;
  assign done      = w_done;
  assign out_valid = w_dp_vld;
  assign y_hat     = w_dp_y;
  assign exercise  = w_dp_ex;
  assign ex_count  = r_ex_cnt;

endmodule

// File: tb/tb_lsm_poly_eval.sv
// Directed bench for lsm_poly_eval: hand-computed y_hat/exercise vectors, run control and reset abort.
module tb_lsm_poly_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] beta0 = '0;
  logic [19:0] beta1 = '0;
  logic        in_valid = 1'b0;
  logic [11:0] x_in = '0;
  logic [11:0] pay_in = '0;
  logic        busy;
  logic        out_valid;
  logic [23:0] y_hat;
  logic        exercise;
  logic        done;
  logic [8:0]  ex_count;

  lsm_poly_eval #(.N(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .beta0     (beta0),
    .beta1     (beta1),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .pay_in    (pay_in),
    .busy      (busy),
    .out_valid (out_valid),
    .y_hat     (y_hat),
    .exercise  (exercise),
    .done      (done),
    .ex_count  (ex_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int n_outv = 0;
  int n_done = 0;

  logic [23:0] q_y[$];
  logic        q_ex[$];
  int          q_cyc[$];
  logic [23:0] m_y;
  logic        m_ex;
  int          m_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard on the falling edge: every result is matched against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        n_outv++;
        if (q_y.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          m_y  = q_y.pop_front();
          m_ex = q_ex.pop_front();
          m_c  = q_cyc.pop_front();
          chk("y_hat", 32'(y_hat), 32'(m_y));
          chk("exercise", 32'(exercise), 32'(m_ex));
          chk("latency", cyc - m_c, 32'd2);
        end
      end
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] p, input logic [23:0] ey, input logic eex);
    while ($urandom_range(0, 3) == 0) tick();
    in_valid = 1'b1;
    x_in     = x;
    pay_in   = p;
    q_y.push_back(ey);
    q_ex.push_back(eex);
    q_cyc.push_back(cyc);
    last_acc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_y_hat"}, 32'(y_hat), 32'd0);
    chk({tag, "_exercise"}, 32'(exercise), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ex_count"}, 32'(ex_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    #2;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Run A: 1.0 + 1.0*x, with mid-run start and coefficient changes that must be ignored.
    beta0 = 20'h00100;
    beta1 = 20'h01000;
    do_start();
    chk("busy_run", 32'(busy), 32'd1);
    beta0 = 20'h7FFFF;
    beta1 = 20'h80000;
    send(12'h020, 12'h040, 24'h000300, 1'b1);
    send(12'h020, 12'h000, 24'h000300, 1'b0);
    send(12'h020, 12'h020, 24'h000300, 1'b0);
    for (int i = 3; i < 256; i++) begin
      if (i == 10) do_start();
      send(12'h020, (i < 102) ? 12'h040 : 12'h010, 24'h000300, (i < 102));
    end
    in_valid = 1'b1;
    x_in     = 12'h020;
    pay_in   = 12'h040;
    tick();
    tick();
    in_valid = 1'b0;
    wait_done(10);
    chk("done_latency", cyc - last_acc, 32'd3);
    chk("ex_count_run_a", 32'(ex_count), 32'd100);
    chk("busy_in_done", 32'(busy), 32'd0);

    // Start held through DONE (ignored) and the following IDLE cycle (accepted).
    beta0 = 20'h7FFFF;
    beta1 = 20'h7FFFF;
    start = 1'b1;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("outv_count_run_a", n_outv, 32'd256);
    chk("done_count_run_a", n_done, 32'd1);
    tick();
    start = 1'b0;
    chk("busy_run_b", 32'(busy), 32'd1);
    chk("ex_count_cleared", 32'(ex_count), 32'd0);

    // Run B: positive saturation, aborted by reset after 50 samples.
    for (int i = 0; i < 50; i++) send(12'hFFF, 12'h000, 24'h7FFFFF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    q_y.delete();
    q_ex.delete();
    q_cyc.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("no_done_after_abort", n_done, 32'd1);
    chk("idle_after_abort", 32'(busy), 32'd0);

    // Run C: negative saturation, every path exercises, ex_count reaches N.
    beta0 = 20'h80000;
    beta1 = 20'h80000;
    n_outv = 0;
    do_start();
    for (int i = 0; i < 256; i++) send(12'hFFF, 12'h001, 24'h800000, 1'b1);
    wait_done(10);
    chk("done_latency_run_c", cyc - last_acc, 32'd3);
    chk("ex_count_run_c", 32'(ex_count), 32'd256);
    tick();
    tick();
    chk("ex_count_held", 32'(ex_count), 32'd256);
    chk("busy_idle_end", 32'(busy), 32'd0);
    chk("outv_count_run_c", n_outv, 32'd256);
    chk("done_count_end", n_done, 32'd2);
    chk("pending_results", q_y.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsm_poly_eval.md
Name: lsm_poly_eval

Overview:
- Streaming evaluator for the fitted regression line in the least-squares option-pricing flow.
- The accumulator and 2x2-inverse blocks reduce a stream of N samples to coefficients. This block runs the other direction: it takes those coefficients and expands them back over the N-sample stream.
- Per sample it produces continuation value y_hat = beta0 + beta1*x and an early-exercise decision.
- It also counts exercised paths for the downstream discounting stage.

Parameters:
- N, 256, samples per run; counter width is clog2(N)+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches coefficients and begins a run (honoured in IDLE only).
- beta0  in  20  signed intercept, 12 integer / 8 fraction bits.
- beta1  in  20  signed slope, 8 integer / 12 fraction bits.
- in_valid  in  1  x_in/pay_in valid this cycle.
- x_in  in  12  unsigned underlying price, 8 integer / 4 fraction bits.
- pay_in  in  12  unsigned exercise payoff, 8 integer / 4 fraction bits.
- busy  out  1  high in RUN and DRAIN.
- out_valid  out  1  y_hat/exercise valid this cycle.
- y_hat  out  24  signed continuation value, 16 integer / 8 fraction bits, saturated.
- exercise  out  1  exercise decision for this sample.
- done  out  1  one-cycle pulse at end of run.
- ex_count  out  9  number of exercise=1 results in the run; held until next start.

Behaviour:
- Reset: all outputs 0, state IDLE, sample counter 0, latched coefficients 0.
- States: IDLE -> RUN -> DRAIN (2 cycles) -> DONE (1 cycle) -> IDLE.
- IDLE:
  - start=1 latches beta0/beta1, clears sample counter and ex_count, and moves to RUN.
  - in_valid is ignored.
- RUN:
  - Each cycle with in_valid=1 accepts one sample and increments the counter.
  - in_valid=0 inserts a bubble; the counter holds and no out_valid is produced 2 cycles later.
  - start is ignored.
  - When the N-th sample is accepted, go to DRAIN; further in_valid is ignored.
- Pipeline, 2-cycle latency (sample in cycle c gives out_valid in c+2):
  - Stage 1 registers prod = beta1 * {0,x_in}, a 20x13 signed multiply giving 33 bits with 16 fraction bits, plus pay_in and a valid bit.
  - Stage 2 sign-extends beta0 to 34 bits, shifts it left 8 (16 fraction bits), and adds prod to form sum (34 bits).
    - y_hat = sum[31:8] when sum[33:31] are all equal.
    - Otherwise y_hat saturates to 24'h7FFFFF (sum positive) or 24'h800000 (sum negative).
    - exercise = (pay_in != 0) && (signed {0,pay_in,4'b0} > y_hat). Out-of-the-money paths never exercise.
    - ex_count increments on out_valid && exercise.
- DRAIN: lasts exactly 2 cycles so the last result exits. DONE then asserts done=1 for one cycle with the final ex_count. Last sample in cycle c gives done in cycle c+3.
- Coefficients stay constant for the whole run; changes on beta0/beta1 after start have no effect.
- Reset mid-run: immediate abort, with the pipeline valid bits, outputs and counters cleared and no done pulse.
- start in the same cycle as done: ignored (state is DONE). start is accepted in the following IDLE cycle.
- ex_count saturates naturally at N (fits in 9 bits); no wrap.

Decomposition:
- Shared package:
  - fixed-point constants: XI_W=12, XI_FRAC=4, B0_W=20, B0_FRAC=8, B1_W=20, B1_FRAC=12, YH_W=24, YH_FRAC=8.
  - state encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- One sub-module, lsm_poly_eval_dp: the two-stage multiply/add/saturate/compare datapath with valid pipeline.
- The top level holds the FSM, sample counter, drain counter and ex_count.

Test Plan:
- Basic value: beta0=20'h00100 (1.0), beta1=20'h01000 (1.0), one sample x_in=12'h020 (2.0), pay_in=12'h040 (4.0). Expect y_hat=24'h000300 and exercise=1, with out_valid exactly 2 cycles after acceptance.
- Out of the money: same coefficients, pay_in=0 and x_in=12'h020. Expect y_hat=24'h000300 and exercise=0. Then pay_in=12'h020 (2.0 < 3.0) also gives exercise=0.
- Saturation: beta0=20'h7FFFF, beta1=20'h7FFFF, x_in=12'hFFF gives y_hat=24'h7FFFFF. beta0=20'h80000, beta1=20'h80000, x_in=12'hFFF gives y_hat=24'h800000.
- Full run with gaps: N=256 samples with in_valid toggling pseudo-randomly and exercise=1 on 100 samples.
  - Expect exactly 256 out_valid pulses and done 3 cycles after the 256th accepted sample.
  - Expect ex_count=100, busy low the cycle after done, and extra in_valid in DRAIN ignored.
- Control edges:
  - start during RUN: no restart, count unaffected.
  - beta inputs changed mid-run: outputs still use the latched values.
  - Back-to-back run: start the cycle after done returns to IDLE; ex_count clears to 0 on that start.
- Reset mid-run: assert rst_n=0 after 50 samples. Expect all outputs 0 immediately, no done pulse, and the next start running a clean full run with correct ex_count.
